// File: rtl/cache_dp_arbiter_pkg.sv
// Shared types and constants for the cache dual-port arbiter: the registered
// read-response record and the miss-counter width.
package cache_dp_arbiter_pkg;

  localparam int MISS_CNT_WIDTH = 16;
  // Response data field width; the top's DATA_WIDTH defaults to this.
  localparam int RESP_DATA_W    = 16;

  typedef struct packed {
    logic                   valid;
    logic                   hit;
    logic [RESP_DATA_W-1:0] data;
  } rd_resp_t;

  function automatic logic [MISS_CNT_WIDTH-1:0] sat_inc(
    input logic [MISS_CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cache_dp_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searched from an internal pointer that
// moves past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_upd,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_cand [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      w_cand[k] = PW'((int'(r_ptr) + k) % N);
    end
  end

  // Walk from the far end so the candidate closest to r_ptr wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    for (int k = N-1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        o_gnt            = '0;
        o_gnt[w_cand[k]] = 1'b1;
        o_idx            = w_cand[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_upd && |i_req) begin
      r_ptr <= (int'(o_idx) == N-1) ? '0 : o_idx + 1'b1;
    end
  end

endmodule

// File: rtl/cache_dp_arbiter.sv
// Arbitrates several writers onto cache port A and several readers onto port B,
// registers the read result with write-to-read forwarding and counts misses.
module cache_dp_arbiter
  import cache_dp_arbiter_pkg::*;
#(
  parameter int IDX_BITS   = 2,
  parameter int DATA_WIDTH = RESP_DATA_W,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WR     = 2,
  parameter int NUM_RD     = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_WR-1:0]                    wr_valid_i,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]    wr_addr_i,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wr_data_i,
  output logic [NUM_WR-1:0]                    wr_ready_o,
  input  logic [NUM_RD-1:0]                    rd_valid_i,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    rd_addr_i,
  output logic [NUM_RD-1:0]                    rd_ready_o,
  output logic [NUM_RD-1:0]                    rd_resp_valid_o,
  output logic [NUM_RD-1:0]                    rd_resp_hit_o,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_resp_data_o,
  output logic [ADDR_WIDTH-1:0]                cache_addra_o,
  output logic [DATA_WIDTH-1:0]                cache_wdata_o,
  output logic                                 cache_cea_o,
  output logic                                 cache_we_o,
  output logic [ADDR_WIDTH-1:0]                cache_addrb_o,
  output logic                                 cache_ceb_o,
  input  logic [DATA_WIDTH-1:0]                cache_rdatab_i,
  input  logic                                 cache_rhitb_i,
  output logic [MISS_CNT_WIDTH-1:0]            miss_count_o
);

  localparam int WPW   = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int RPW   = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
  localparam int TAG_W = ADDR_WIDTH - IDX_BITS;

  logic [NUM_WR-1:0]     w_wr_gnt;
  logic [WPW-1:0]        w_wr_idx;
  logic                  w_wr_any;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;

  logic [NUM_RD-1:0]     w_rd_gnt;
  logic [RPW-1:0]        w_rd_idx;
  logic                  w_rd_any;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  logic                  w_same_idx;
  logic                  w_same_tag;
  logic                  w_fwd;
  logic                  w_hit;
  logic [DATA_WIDTH-1:0] w_data;

  rd_resp_t                  r_resp;
  logic [NUM_RD-1:0]         r_resp_lane;
  logic [MISS_CNT_WIDTH-1:0] r_miss_cnt;

  // Every grant is a completed transfer, so pointers always advance on grant.
  rr_arbiter #(.N(NUM_WR)) u_wr_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (wr_valid_i),
    .i_upd   (1'b1),
    .o_gnt   (w_wr_gnt),
    .o_idx   (w_wr_idx)
  );

  rr_arbiter #(.N(NUM_RD)) u_rd_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (rd_valid_i),
    .i_upd   (1'b1),
    .o_gnt   (w_rd_gnt),
    .o_idx   (w_rd_idx)
  );

  assign w_wr_any  = |w_wr_gnt;
  assign w_wr_addr = wr_addr_i[w_wr_idx];
  assign w_wr_data = wr_data_i[w_wr_idx];
  assign w_rd_any  = |w_rd_gnt;
  assign w_rd_addr = rd_addr_i[w_rd_idx];

  assign wr_ready_o    = w_wr_gnt & {NUM_WR{reset_n}};
  assign cache_cea_o   = w_wr_any & reset_n;
  assign cache_we_o    = w_wr_any & reset_n;
  assign cache_addra_o = w_wr_any ? w_wr_addr : '0;
  assign cache_wdata_o = w_wr_any ? w_wr_data : '0;

  assign rd_ready_o    = w_rd_gnt & {NUM_RD{reset_n}};
  assign cache_ceb_o   = w_rd_any & reset_n;
  assign cache_addrb_o = w_rd_any ? w_rd_addr : '0;

  // Only a full-address match forwards; same index with another tag is left
  // to the cache, whose array still holds the old line this cycle.
  assign w_same_idx = w_wr_addr[IDX_BITS-1:0] == w_rd_addr[IDX_BITS-1:0];
  assign w_same_tag = w_wr_addr[ADDR_WIDTH-1 -: TAG_W] == w_rd_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_fwd      = w_wr_any & w_rd_any & w_same_idx & w_same_tag;
  assign w_hit      = w_fwd | cache_rhitb_i;
  assign w_data     = w_fwd ? w_wr_data : (cache_rhitb_i ? cache_rdatab_i : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_resp      <= '0;
      r_resp_lane <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_resp.valid <= w_rd_any;
      r_resp.hit   <= w_rd_any & w_hit;
      r_resp.data  <= (w_rd_any && w_hit) ? RESP_DATA_W'(w_data) : '0;
      r_resp_lane  <= w_rd_gnt;
      if (w_rd_any && !w_hit) begin
        r_miss_cnt <= sat_inc(r_miss_cnt);
      end
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd_resp
    assign rd_resp_valid_o[j] = r_resp.valid & r_resp_lane[j];
    assign rd_resp_hit_o[j]   = r_resp.valid & r_resp_lane[j] & r_resp.hit;
    assign rd_resp_data_o[j]  = rd_resp_hit_o[j] ? DATA_WIDTH'(r_resp.data) : '0;
  end

  assign miss_count_o = r_miss_cnt;

endmodule

// File: doc/cache_dp_arbiter.md
CACHE_DP_ARBITER -- requirements
Module: cache_dp_arbiter

Interface
REQ-001 SHALL have parameter IDX_BITS, default 2, cache index width; the cache holds 2**IDX_BITS entries.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, full address width; tag width = ADDR_WIDTH-IDX_BITS.
REQ-004 SHALL have parameter NUM_WR, default 2, number of write requesters.
REQ-005 SHALL have parameter NUM_RD, default 2, number of read requesters.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port wr_valid_i / wr_addr_i / wr_data_i  input  NUM_WR x (1 / ADDR_WIDTH / DATA_WIDTH)  write requests.
REQ-009 SHALL have port wr_ready_o  output  NUM_WR  write grant; the transfer completes on that edge.
REQ-010 SHALL have port rd_valid_i / rd_addr_i  input  NUM_RD x (1 / ADDR_WIDTH)  read requests.
REQ-011 SHALL have port rd_ready_o  output  NUM_RD  read grant.
REQ-012 SHALL have port rd_resp_valid_o / rd_resp_hit_o / rd_resp_data_o  output  NUM_RD x (1 / 1 / DATA_WIDTH)  registered read response.
REQ-013 SHALL have port cache_addra_o / cache_wdata_o / cache_cea_o / cache_we_o  output  ADDR_WIDTH / DATA_WIDTH / 1 / 1  cache port A, write only.
REQ-014 SHALL have port cache_addrb_o / cache_ceb_o  output  ADDR_WIDTH / 1  cache port B, read only.
REQ-015 SHALL have port cache_rdatab_i / cache_rhitb_i  input  DATA_WIDTH / 1  cache port B combinational read result.
REQ-016 SHALL have port miss_count_o  output  16  saturating count of read misses.

Function
REQ-017 SHALL select at most one write requester per cycle by round-robin, starting the search at wr_ptr.
REQ-018 SHALL, on a write grant to requester i, drive wr_ready_o[i]=1, cache_cea_o=1, cache_we_o=1 and cache_addra_o/cache_wdata_o from requester i, all in the same cycle.
REQ-019 SHALL hold cache_cea_o=0 and cache_we_o=0 when no write is valid; wr_ptr then SHALL stay unchanged.
REQ-020 SHALL set wr_ptr to (granted index+1) mod NUM_WR after each write grant.
REQ-021 SHALL arbitrate reads independently by round-robin on rd_ptr, with at most one grant per cycle, and drive cache_ceb_o=1 and cache_addrb_o for the granted requester.
REQ-022 SHALL register the read result: 1 cycle after the grant of requester j, pulse rd_resp_valid_o[j]=1 for exactly 1 cycle with hit and data.
REQ-023 SHALL forward on a collision: if a write and a read in the same cycle have equal full addresses, the response SHALL be hit=1 with data=write data.
REQ-024 SHALL, on a same-cycle write and read to the same index with a different tag, return the cache result unmodified.
REQ-025 SHALL drive rd_resp_data_o=0 whenever rd_resp_hit_o=0.
REQ-026 SHALL increment miss_count_o on each response with hit=0, and saturate at 16'hFFFF.
REQ-027 SHALL give a requester holding valid a grant within NUM_WR cycles (write) or NUM_RD cycles (read).
REQ-028 SHALL not depend on a requester's grant to lower its valid; valid may drop without a grant.

Reset
REQ-029 SHALL, on reset_n=0, asynchronously clear wr_ptr, rd_ptr, all rd_resp_* outputs and miss_count_o to 0.
REQ-030 SHALL drop an in-flight read response on reset; no response pulse SHALL appear after reset deasserts.
REQ-031 SHALL force cache_cea_o, cache_we_o, cache_ceb_o, wr_ready_o and rd_ready_o to 0 while reset_n=0.

Structure
REQ-032 SHALL place the response struct (valid, hit, data) and the MISS_CNT_WIDTH=16 constant in the shared common package.
REQ-033 SHALL implement both arbiters as a single sub-module rr_arbiter (parameter N; ports req, ptr update, one-hot grant), instantiated twice.

Verification
REQ-034 Both writers valid for 4 cycles -> grants alternate 0,1,0,1 and cache_we_o=1 in each cycle.
REQ-035 Write 0x1234 to addr 0x05, then read 0x05 from requester 1 -> the next cycle gives rd_resp_valid_o[1]=1, hit=1, data=0x1234.
REQ-036 Same-cycle write 0xBEEF to 0x09 and read of 0x09 -> response hit=1, data=0xBEEF.
REQ-037 Read of 0x45 after a write to 0x05 (same index, other tag) -> hit=0, data=0, miss_count_o=1.
REQ-038 Preload miss_count_o to 0xFFFE via forced misses, then 3 more misses -> the count holds at 0xFFFF.
REQ-039 Assert reset_n low in the cycle after a read grant -> no response pulse, and all outputs read 0.
